// File: rtl/dram_arbiter.sv
// Round-robin arbiter sharing one data-RAM port between N cores and an
// external loader/dump port. The external port has fixed priority. Each access
// takes ISSUE (1 cycle) for a write, or ISSUE + RWAIT (2 cycles) for a read.
`timescale 1ns/1ps
module dram_arbiter #(
  parameter int N_CORES = 4,
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [N_CORES-1:0]          core_req,
  input  logic [N_CORES-1:0]          core_we,
  input  logic [N_CORES*ADDR_W-1:0]   core_addr,
  input  logic [N_CORES*DATA_W-1:0]   core_wdata,
  output logic [N_CORES-1:0]          core_gnt,
  output logic [N_CORES-1:0]          core_rvalid,
  input  logic                        ext_req,
  input  logic                        ext_we,
  input  logic [ADDR_W-1:0]           ext_addr,
  input  logic [DATA_W-1:0]           ext_wdata,
  output logic                        ext_gnt,
  output logic                        ext_rvalid,
  output logic [DATA_W-1:0]           rdata,
  output logic                        mem_en,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata
);

  localparam int PTR_W = $clog2(N_CORES);
  localparam int SUM_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, RWAIT} state_t;

  state_t               state_q, state_d;
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]     owner_q, owner_d;
  logic                 owner_ext_q, owner_ext_d;
  logic [N_CORES-1:0]   core_gnt_q, core_gnt_d;
  logic [N_CORES-1:0]   core_rvalid_q, core_rvalid_d;
  logic                 ext_gnt_q, ext_gnt_d;
  logic                 ext_rvalid_q, ext_rvalid_d;
  logic [DATA_W-1:0]    rdata_q, rdata_d;
  logic                 mem_en_q, mem_en_d;
  logic                 mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]    mem_wdata_q, mem_wdata_d;

  logic                 win_found;
  logic [PTR_W-1:0]     win_idx;
  logic [SUM_W-1:0]     cand;
  logic [ADDR_W-1:0]    addr_arr  [N_CORES];
  logic [DATA_W-1:0]    wdata_arr [N_CORES];

  // Unpack per-core address/data buses so the winner can be selected by index
  for (genvar g = 0; g < N_CORES; g++) begin : g_unpack
    assign addr_arr[g]  = core_addr[g*ADDR_W +: ADDR_W];
    assign wdata_arr[g] = core_wdata[g*DATA_W +: DATA_W];
  end

  // Pick the first requesting core at or after rr_ptr, wrapping modulo N_CORES
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < N_CORES; i++) begin
      cand = {1'b0, rr_ptr_q} + SUM_W'(i);
      if (cand >= SUM_W'(N_CORES)) cand = cand - SUM_W'(N_CORES);
      if (!win_found && core_req[cand[PTR_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[PTR_W-1:0];
      end
    end
  end

  // Next-state and registered-output logic; strobes default to 0 every cycle
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    owner_d       = owner_q;
    owner_ext_d   = owner_ext_q;
    core_gnt_d    = '0;
    core_rvalid_d = '0;
    ext_gnt_d     = 1'b0;
    ext_rvalid_d  = 1'b0;
    rdata_d       = rdata_q;
    mem_en_d      = 1'b0;
    mem_we_d      = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    case (state_q)
      IDLE: begin
        if (ext_req) begin
          ext_gnt_d   = 1'b1;
          owner_ext_d = 1'b1;
          mem_en_d    = 1'b1;
          mem_we_d    = ext_we;
          mem_addr_d  = ext_addr;
          mem_wdata_d = ext_wdata;
          state_d     = ISSUE;
        end else if (win_found) begin
          core_gnt_d[win_idx] = 1'b1;
          owner_ext_d = 1'b0;
          owner_d     = win_idx;
          mem_en_d    = 1'b1;
          mem_we_d    = core_we[win_idx];
          mem_addr_d  = addr_arr[win_idx];
          mem_wdata_d = wdata_arr[win_idx];
          rr_ptr_d    = (win_idx == PTR_W'(N_CORES - 1)) ? '0 : win_idx + PTR_W'(1);
          state_d     = ISSUE;
        end
      end
      ISSUE: state_d = mem_we_q ? IDLE : RWAIT;
      RWAIT: begin
        rdata_d = mem_rdata;
        if (owner_ext_q) ext_rvalid_d = 1'b1;
        else             core_rvalid_d[owner_q] = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      owner_q       <= '0;
      owner_ext_q   <= 1'b0;
      core_gnt_q    <= '0;
      core_rvalid_q <= '0;
      ext_gnt_q     <= 1'b0;
      ext_rvalid_q  <= 1'b0;
      rdata_q       <= '0;
      mem_en_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      owner_q       <= owner_d;
      owner_ext_q   <= owner_ext_d;
      core_gnt_q    <= core_gnt_d;
      core_rvalid_q <= core_rvalid_d;
      ext_gnt_q     <= ext_gnt_d;
      ext_rvalid_q  <= ext_rvalid_d;
      rdata_q       <= rdata_d;
      mem_en_q      <= mem_en_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
    end
  end

  assign core_gnt    = core_gnt_q;
  assign core_rvalid = core_rvalid_q;
  assign ext_gnt     = ext_gnt_q;
  assign ext_rvalid  = ext_rvalid_q;
  assign rdata       = rdata_q;
  assign mem_en      = mem_en_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;

endmodule

// File: tb/tb_dram_arbiter.sv
// Bench for dram_arbiter: grant-selection table, hand-written multi-cycle
// sequences, and a randomized run against a transaction-level model.
`timescale 1ns/1ps
module tb_dram_arbiter;

  localparam int N  = 4;
  localparam int AW = 9;
  localparam int DW = 16;

  logic            clock = 1'b0;
  logic            reset;
  logic [N-1:0]    core_req, core_we, core_gnt, core_rvalid;
  logic [N*AW-1:0] core_addr;
  logic [N*DW-1:0] core_wdata;
  logic            ext_req, ext_we, ext_gnt, ext_rvalid;
  logic [AW-1:0]   ext_addr, mem_addr;
  logic [DW-1:0]   ext_wdata, rdata, mem_wdata, mem_rdata;
  logic            mem_en, mem_we;

  logic            c_req   [N];
  logic            c_we    [N];
  logic [AW-1:0]   c_addr  [N];
  logic [DW-1:0]   c_wdata [N];

  logic [DW-1:0]   ram    [0:(1<<AW)-1];
  logic [DW-1:0]   shadow [0:(1<<AW)-1];
  logic            ram_clear;

  int checks   = 0;
  int failures = 0;

  dram_arbiter #(.N_CORES(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clock(clock), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_rvalid(core_rvalid),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .rdata(rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign core_req[g]             = c_req[g];
    assign core_we[g]              = c_we[g];
    assign core_addr[g*AW +: AW]   = c_addr[g];
    assign core_wdata[g*DW +: DW]  = c_wdata[g];
  end

  // Synchronous single-port RAM: read data valid one cycle after the enabled edge
  always @(posedge clock) begin
    if (ram_clear) begin
      for (int a = 0; a < (1<<AW); a++) ram[a] <= '0;
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clock);
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < N; i++) begin
      c_req[i] = 1'b0; c_we[i] = 1'b0; c_addr[i] = '0; c_wdata[i] = '0;
    end
    ext_req = 1'b0; ext_we = 1'b0; ext_addr = '0; ext_wdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    clear_inputs();
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic set_core(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    c_req[i] = 1'b1; c_we[i] = we; c_addr[i] = a; c_wdata[i] = d;
  endtask

  typedef struct {
    int         prime;   // core granted one write beforehand to set the pointer, -1 = none
    logic       ext;
    logic [3:0] req;
    logic [3:0] we;
    logic [3:0] egnt;
    logic       eext;
    logic       ewe;
    logic [8:0] eaddr;
  } vec_t;

  vec_t tbl [9];

  // Transaction-level reference state for the randomized run
  int            m_rr, m_free, rv_at, rv_who, nxt_who, cur_who;
  logic          nxt_we, cur_we;
  logic [AW-1:0] nxt_addr, cur_addr;
  logic [DW-1:0] nxt_wdata, cur_wdata, rv_data, last_rdata;
  logic [3:0]    e_gnt, e_rv;
  logic          e_eg, e_erv;

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    ram_clear = 1'b1;
    clear_inputs();
    for (int a = 0; a < (1<<AW); a++) shadow[a] = '0;
    nxt(); nxt();
    ram_clear = 1'b0;
    reset = 1'b0;

    // Reset state
    do_reset();
    nxt();
    chk("reset_strobes", 32'({core_gnt, core_rvalid, ext_gnt, ext_rvalid, mem_en, mem_we}), 32'(0));
    chk("reset_addr_data", 32'({mem_addr, rdata}), 32'(0));

    // Grant-selection table: core i uses address 0x20+i, ext uses 0x1AA
    tbl[0] = '{-1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 9'h000};
    tbl[1] = '{-1, 1'b0, 4'b0001, 4'b0001, 4'b0001, 1'b0, 1'b1, 9'h020};
    tbl[2] = '{-1, 1'b0, 4'b1110, 4'b0000, 4'b0010, 1'b0, 1'b0, 9'h021};
    tbl[3] = '{ 0, 1'b0, 4'b0001, 4'b0001, 4'b0001, 1'b0, 1'b1, 9'h020};
    tbl[4] = '{ 2, 1'b0, 4'b1001, 4'b1001, 4'b1000, 1'b0, 1'b1, 9'h023};
    tbl[5] = '{ 3, 1'b0, 4'b1001, 4'b1001, 4'b0001, 1'b0, 1'b1, 9'h020};
    tbl[6] = '{ 1, 1'b1, 4'b1111, 4'b1111, 4'b0000, 1'b1, 1'b0, 9'h1AA};
    tbl[7] = '{ 1, 1'b0, 4'b0011, 4'b0010, 4'b0001, 1'b0, 1'b0, 9'h020};
    tbl[8] = '{ 3, 1'b0, 4'b1100, 4'b0100, 4'b0100, 1'b0, 1'b1, 9'h022};
    for (int t = 0; t < 9; t++) begin
      do_reset();
      if (tbl[t].prime >= 0) begin
        set_core(tbl[t].prime, 1'b1, 9'h0, 16'h0);
        nxt();
        c_req[tbl[t].prime] = 1'b0;
        nxt(); nxt(); nxt();
      end
      for (int i = 0; i < N; i++) begin
        c_req[i] = tbl[t].req[i]; c_we[i] = tbl[t].we[i];
        c_addr[i] = 9'(32'h20 + i); c_wdata[i] = 16'(32'h1000 * (i + 1));
      end
      ext_req = tbl[t].ext; ext_we = 1'b0; ext_addr = 9'h1AA; ext_wdata = 16'hA5A5;
      nxt();
      chk($sformatf("tbl%0d_grant", t), 32'({core_gnt, ext_gnt, mem_en, mem_we}),
          32'({tbl[t].egnt, tbl[t].eext, (|tbl[t].egnt) | tbl[t].eext, tbl[t].ewe}));
      if ((|tbl[t].egnt) | tbl[t].eext) chk($sformatf("tbl%0d_addr", t), 32'(mem_addr), 32'(tbl[t].eaddr));
      clear_inputs();
      nxt(); nxt(); nxt(); nxt();
    end

    // Core 2 writes 0xBEEF to 0x05 then reads it back
    do_reset();
    set_core(2, 1'b1, 9'h005, 16'hBEEF);
    nxt();
    chk("wr_grant", 32'({core_gnt, mem_en, mem_we}), 32'({4'b0100, 1'b1, 1'b1}));
    chk("wr_addr_data", 32'({mem_addr, mem_wdata}), 32'({9'h005, 16'hBEEF}));
    c_req[2] = 1'b0;
    nxt();
    chk("wr_done", 32'({core_gnt, mem_en, mem_we}), 32'(0));
    set_core(2, 1'b0, 9'h005, 16'h0000);
    nxt();
    chk("rd_grant", 32'({core_gnt, mem_en, mem_we}), 32'({4'b0100, 1'b1, 1'b0}));
    c_req[2] = 1'b0;
    nxt();
    chk("rd_wait", 32'({core_rvalid, mem_en}), 32'(0));
    nxt();
    chk("rd_valid", 32'({core_rvalid, rdata}), 32'({4'b0100, 16'hBEEF}));
    nxt();
    chk("rd_pulse_end", 32'({core_rvalid, rdata}), 32'({4'b0000, 16'hBEEF}));

    // Reset while a read is waiting for data
    set_core(0, 1'b0, 9'h005, 16'h0);
    nxt();
    c_req[0] = 1'b0;
    nxt();
    reset = 1'b1;
    #1;
    chk("rst_mid_read", 32'({core_rvalid, mem_en, rdata}), 32'(0));
    nxt();
    chk("rst_no_rvalid", 32'({core_rvalid, ext_rvalid, rdata}), 32'(0));
    set_core(1, 1'b1, 9'h007, 16'h0077);
    reset = 1'b0;
    nxt();
    chk("rst_first_grant", 32'({core_gnt, mem_we, mem_addr}), 32'({4'b0010, 1'b1, 9'h007}));
    clear_inputs();
    nxt(); nxt();

    // All cores hold writes: grant order 0,1,2,3,... one every two cycles
    do_reset();
    for (int i = 0; i < N; i++) set_core(i, 1'b1, 9'(i), 16'(i));
    for (int g = 0; g < 8; g++) begin
      nxt();
      chk($sformatf("rr_grant%0d", g), 32'(core_gnt), 32'(4'b0001 << (g % 4)));
      nxt();
      chk($sformatf("rr_gap%0d", g), 32'(core_gnt), 32'(0));
    end
    clear_inputs();
    nxt(); nxt();

    // External priority leaves the pointer alone
    do_reset();
    set_core(1, 1'b1, 9'h0, 16'h0);
    nxt();
    chk("ext_prime", 32'(core_gnt), 32'(4'b0010));
    c_req[1] = 1'b0;
    nxt();
    for (int i = 0; i < N; i++) set_core(i, 1'b1, 9'(i), 16'(i));
    ext_req = 1'b1; ext_we = 1'b1; ext_addr = 9'h1AA; ext_wdata = 16'h5555;
    nxt();
    chk("ext_first", 32'({core_gnt, ext_gnt}), 32'({4'b0000, 1'b1}));
    ext_req = 1'b0;
    nxt();
    nxt();
    chk("ext_resume0", 32'({core_gnt, ext_gnt}), 32'({4'b0100, 1'b0}));
    nxt(); nxt();
    chk("ext_resume1", 32'(core_gnt), 32'(4'b1000));
    nxt(); nxt();
    chk("ext_resume2", 32'(core_gnt), 32'(4'b0001));
    clear_inputs();
    nxt(); nxt();

    // Back-to-back reads from cores 1 and 3
    do_reset();
    ext_req = 1'b1; ext_we = 1'b1; ext_addr = 9'h010; ext_wdata = 16'h1234;
    nxt();
    chk("pre_wr0", 32'(ext_gnt), 32'(1));
    ext_addr = 9'h1FF; ext_wdata = 16'hFFFF;
    nxt(); nxt();
    chk("pre_wr1", 32'(ext_gnt), 32'(1));
    ext_req = 1'b0;
    nxt();
    set_core(1, 1'b0, 9'h010, 16'h0);
    set_core(3, 1'b0, 9'h1FF, 16'h0);
    for (int c = 1; c <= 6; c++) begin
      logic [3:0] eg, ev;
      eg = (c == 1) ? 4'b0010 : (c == 4) ? 4'b1000 : 4'b0000;
      ev = (c == 3) ? 4'b0010 : (c == 6) ? 4'b1000 : 4'b0000;
      nxt();
      chk($sformatf("b2b_c%0d", c), 32'({core_gnt, core_rvalid}), 32'({eg, ev}));
      if (c == 3) chk("b2b_data1", 32'(rdata), 32'(16'h1234));
      if (c == 6) chk("b2b_data3", 32'(rdata), 32'(16'hFFFF));
      if (c == 1) c_req[1] = 1'b0;
      if (c == 4) c_req[3] = 1'b0;
    end

    // Randomized traffic against the transaction-level model
    @(negedge clock);
    reset = 1'b1; ram_clear = 1'b1;
    clear_inputs();
    for (int a = 0; a < (1<<AW); a++) shadow[a] = '0;
    @(negedge clock);
    reset = 1'b0; ram_clear = 1'b0;
    m_rr = 0; m_free = 0; rv_at = -1; rv_who = -1; nxt_who = -1;
    nxt_we = 1'b0; nxt_addr = '0; nxt_wdata = '0; rv_data = '0; last_rdata = '0;
    for (int k = 0; k < 800; k++) begin
      @(negedge clock);
      cur_who = nxt_who; cur_we = nxt_we; cur_addr = nxt_addr; cur_wdata = nxt_wdata;
      nxt_who = -1;
      e_gnt = '0; e_eg = 1'b0; e_rv = '0; e_erv = 1'b0;
      if (cur_who == N) e_eg = 1'b1;
      else if (cur_who >= 0) e_gnt = 4'b0001 << cur_who;
      if (rv_at == k) begin
        last_rdata = rv_data;
        if (rv_who == N) e_erv = 1'b1;
        else e_rv = 4'b0001 << rv_who;
      end
      chk($sformatf("rnd%0d_strobes", k),
          32'({core_gnt, ext_gnt, core_rvalid, ext_rvalid, mem_en, mem_we}),
          32'({e_gnt, e_eg, e_rv, e_erv, cur_who >= 0, (cur_who >= 0) & cur_we}));
      if (cur_who >= 0)
        chk($sformatf("rnd%0d_port", k), 32'({mem_addr, mem_wdata}), 32'({cur_addr, cur_wdata}));
      chk($sformatf("rnd%0d_rdata", k), 32'(rdata), 32'(last_rdata));

      // Requesters drop on their grant and may start a new access at any time
      for (int i = 0; i < N; i++) begin
        if (cur_who == i) c_req[i] = 1'b0;
        if (!c_req[i] && $urandom_range(0, 3) == 0)
          set_core(i, 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 7) == 0) ? 9'h1FF : 9'($urandom_range(0, 15)),
                   16'($urandom));
      end
      if (cur_who == N) ext_req = 1'b0;
      if (!ext_req && $urandom_range(0, 15) == 0) begin
        ext_req = 1'b1; ext_we = 1'($urandom_range(0, 1));
        ext_addr = 9'($urandom_range(0, 15)); ext_wdata = 16'($urandom);
      end

      // Predict the grant at the coming edge
      if (k + 1 >= m_free) begin
        int w;
        w = -1;
        if (ext_req) w = N;
        else
          for (int j = 0; j < N; j++)
            if (w < 0 && c_req[(m_rr + j) % N]) w = (m_rr + j) % N;
        if (w >= 0) begin
          nxt_who = w;
          if (w == N) begin
            nxt_we = ext_we; nxt_addr = ext_addr; nxt_wdata = ext_wdata;
          end else begin
            nxt_we = c_we[w]; nxt_addr = c_addr[w]; nxt_wdata = c_wdata[w];
            m_rr = (w + 1) % N;
          end
          if (nxt_we) begin
            shadow[nxt_addr] = nxt_wdata;
            m_free = k + 3;
          end else begin
            rv_at = k + 3; rv_who = w; rv_data = shadow[nxt_addr];
            m_free = k + 4;
          end
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
